// File: rtl/coherence_lru_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_lru_ctrl
//
// Per-cache coherence and replacement controller sitting between an L1 cache
// block and the shared snoop bus.
//   - Keeps one tree-PLRU word (ASSOCIATIVITY-1 bits) per set. After reset a
//     sweep zeroes one set per cycle; requests are accepted only afterwards.
//   - Processor channel: returns the registered MESI next state and the PLRU
//     victim way (as seen before this access updates the tree).
//   - Snoop channel: returns the registered MESI next state and a flush flag
//     when dirty data must be supplied or written back.
//   Both channels are independent and respond one cycle after acceptance
//   with a single-cycle valid pulse.
//
// Configuration macro: MESI_EXCLUSIVE_EN
//   defined   -> full MESI; a read miss with no sharers installs E.
//   undefined -> MSI behaviour; a read miss always installs S.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   init_done                       PLRU sweep finished
//   proc_req_valid, PrRd, PrWr      processor request (both set = write)
//   Index_proc, hit, Blk_accessed   set index, tag hit, hitting way
//   Current_MESI_state_proc, Shared current line state, line shared elsewhere
//   proc_rsp_valid                  one-cycle processor response pulse
//   Updated_MESI_state_proc         next state of the processor line
//   LRU_replacement_proc            victim way before this access's update
//   snoop_req_valid                 snoop request strobe
//   BusRd, BusRdX, Invalidate       bus command (BusRdX > Invalidate > BusRd)
//   Current_MESI_state_snoop        snooped line state
//   snoop_rsp_valid                 one-cycle snoop response pulse
//   Updated_MESI_state_snoop        next state of the snooped line
//   snoop_flush                     snooped line is M and a command is present
// ---------------------------------------------------------------------------
module coherence_lru_ctrl #(
  parameter int ASSOCIATIVITY = 4,
  parameter int NUM_OF_SETS   = 256,
  parameter int MESI_SIZE     = 2,
  localparam int WAY_BITS     = $clog2(ASSOCIATIVITY),
  localparam int INDEX_SIZE   = $clog2(NUM_OF_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  // processor channel
  input  logic                  proc_req_valid,
  input  logic                  PrRd,
  input  logic                  PrWr,
  input  logic [INDEX_SIZE-1:0] Index_proc,
  input  logic                  hit,
  input  logic [WAY_BITS-1:0]   Blk_accessed,
  input  logic [MESI_SIZE-1:0]  Current_MESI_state_proc,
  input  logic                  Shared,
  output logic                  proc_rsp_valid,
  output logic [MESI_SIZE-1:0]  Updated_MESI_state_proc,
  output logic [WAY_BITS-1:0]   LRU_replacement_proc,
  // snoop channel
  input  logic                  snoop_req_valid,
  input  logic                  BusRd,
  input  logic                  BusRdX,
  input  logic                  Invalidate,
  input  logic [MESI_SIZE-1:0]  Current_MESI_state_snoop,
  output logic                  snoop_rsp_valid,
  output logic [MESI_SIZE-1:0]  Updated_MESI_state_snoop,
  output logic                  snoop_flush
);

  localparam int TREE_BITS = ASSOCIATIVITY - 1;

  localparam logic [MESI_SIZE-1:0] MESI_I = MESI_SIZE'(0);
  localparam logic [MESI_SIZE-1:0] MESI_S = MESI_SIZE'(1);
  localparam logic [MESI_SIZE-1:0] MESI_E = MESI_SIZE'(2);
  localparam logic [MESI_SIZE-1:0] MESI_M = MESI_SIZE'(3);

  // PLRU table and sweep state
  logic [TREE_BITS-1:0]  r_lru [NUM_OF_SETS];
  logic [INDEX_SIZE-1:0] r_sweep_idx;
  logic                  r_init_done;

  // registered responses
  logic                  r_proc_rsp_valid;
  logic [MESI_SIZE-1:0]  r_upd_proc;
  logic [WAY_BITS-1:0]   r_lru_repl;
  logic                  r_snoop_rsp_valid;
  logic [MESI_SIZE-1:0]  r_upd_snoop;
  logic                  r_snoop_flush;

  logic                  w_proc_accept;
  logic                  w_snoop_accept;
  logic [TREE_BITS-1:0]  w_tree;
  logic [TREE_BITS-1:0]  w_new_tree;
  logic [WAY_BITS-1:0]   w_victim;
  logic [WAY_BITS-1:0]   w_target;
  logic [MESI_SIZE-1:0]  w_proc_cur;
  logic [MESI_SIZE-1:0]  w_proc_next;
  logic [MESI_SIZE-1:0]  w_snoop_next;
  logic                  w_snoop_cmd;

  // rst in the same cycle overrides acceptance on both channels.
  assign w_proc_accept  = proc_req_valid  & r_init_done & ~rst;
  assign w_snoop_accept = snoop_req_valid & r_init_done & ~rst;

  assign w_tree   = r_lru[Index_proc];
  assign w_target = hit ? Blk_accessed : w_victim;

  // Victim walk: a 0 bit sends us to the left child (2i+1), a 1 bit to the
  // right child (2i+2). The bits taken, MSB first, spell the way number.
  always_comb begin
    int            node;
    logic [TREE_BITS-1:0] sh;
    // NOTE: every variable driven here gets a value before any branch or
    // loop, so the block can never hold a stale value and infer a latch.
    node     = 0;
    sh       = '0;
    w_victim = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      sh       = w_tree >> node;
      w_victim = (w_victim << 1) | WAY_BITS'(sh[0]);
      node     = 2 * node + 1 + int'(sh[0]);
    end
  end

  // Touch: each node on the path to the target is pointed at the other
  // subtree, so the target becomes the most recently used way.
  always_comb begin
    int                  node;
    logic [WAY_BITS-1:0] ts;
    node       = 0;
    ts         = '0;
    w_new_tree = w_tree;
    for (int l = 0; l < WAY_BITS; l++) begin
      ts         = w_target >> (WAY_BITS - 1 - l);
      w_new_tree = (w_new_tree & ~(TREE_BITS'(1) << node))
                 | (TREE_BITS'(!ts[0]) << node);
      node       = 2 * node + 1 + int'(ts[0]);
    end
  end

  // Processor MESI: a miss is decoded as if the line were Invalid.
  assign w_proc_cur = hit ? Current_MESI_state_proc : MESI_I;

`ifdef MESI_EXCLUSIVE_EN
  always_comb begin
    w_proc_next = w_proc_cur;
    if (PrWr) begin
      w_proc_next = MESI_M;
    end else if (PrRd && (w_proc_cur == MESI_I)) begin
      w_proc_next = Shared ? MESI_S : MESI_E;
    end
  end
`else
  // Sharing information is irrelevant when E is never installed.
  logic w_unused_shared;
  assign w_unused_shared = Shared;

  always_comb begin
    w_proc_next = w_proc_cur;
    if (PrWr) begin
      w_proc_next = MESI_M;
    end else if (PrRd && (w_proc_cur == MESI_I)) begin
      w_proc_next = MESI_S;
    end
  end
`endif

  // Snoop MESI: BusRdX and Invalidate both kill the line; BusRd demotes
  // M/E to S. E on the input is still handled even in MSI mode.
  assign w_snoop_cmd = BusRd | BusRdX | Invalidate;

  always_comb begin
    w_snoop_next = Current_MESI_state_snoop;
    if (BusRdX || Invalidate) begin
      w_snoop_next = MESI_I;
    end else if (BusRd) begin
      w_snoop_next = (Current_MESI_state_snoop == MESI_I) ? MESI_I : MESI_S;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_init_done       <= 1'b0;
      r_sweep_idx       <= '0;
      r_proc_rsp_valid  <= 1'b0;
      r_upd_proc        <= MESI_I;
      r_lru_repl        <= '0;
      r_snoop_rsp_valid <= 1'b0;
      r_upd_snoop       <= MESI_I;
      r_snoop_flush     <= 1'b0;
    end else begin
      if (!r_init_done) begin
        r_sweep_idx <= r_sweep_idx + INDEX_SIZE'(1);
        if (r_sweep_idx == INDEX_SIZE'(NUM_OF_SETS - 1)) begin
          r_init_done <= 1'b1;
        end
      end

      r_proc_rsp_valid <= w_proc_accept;
      if (w_proc_accept) begin
        r_upd_proc <= w_proc_next;
        r_lru_repl <= w_victim;
      end

      r_snoop_rsp_valid <= w_snoop_accept;
      if (w_snoop_accept) begin
        r_upd_snoop   <= w_snoop_next;
        r_snoop_flush <= (Current_MESI_state_snoop == MESI_M) & w_snoop_cmd;
      end
    end
  end

  // PLRU table. The sweep doubles as the table's clear, and a same-set
  // request on the following edge already reads the updated tree.
  always_ff @(posedge clk) begin
    // NOTE: the table itself is not reset; the post-reset sweep clears it one
    // set per cycle, which keeps it mappable onto plain RAM.
    if (!rst) begin
      if (!r_init_done) begin
        r_lru[r_sweep_idx] <= '0;
      end else if (w_proc_accept && (PrRd || PrWr)) begin
        r_lru[Index_proc] <= w_new_tree;
      end
    end
  end

  assign init_done                = r_init_done;
  assign proc_rsp_valid           = r_proc_rsp_valid;
  assign Updated_MESI_state_proc  = r_upd_proc;
  assign LRU_replacement_proc     = r_lru_repl;
  assign snoop_rsp_valid          = r_snoop_rsp_valid;
  assign Updated_MESI_state_snoop = r_upd_snoop;
  assign snoop_flush              = r_snoop_flush;

endmodule

// File: tb/tb_coherence_lru_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_lru_ctrl
//
// Directed plus randomized bench for coherence_lru_ctrl (4 ways, 256 sets).
// Expected values come from a reference model that stores each set's PLRU
// tree as an array of node bits and derives MESI transitions from the
// protocol tables. Honours MESI_EXCLUSIVE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_coherence_lru_ctrl;

  localparam int ASSOC = 4;
  localparam int SETS  = 256;
  localparam int WB    = 2;
  localparam int ST_I  = 0;
  localparam int ST_S  = 1;
  localparam int ST_E  = 2;
  localparam int ST_M  = 3;

  logic       clk;
  logic       rst;
  logic       init_done;
  logic       proc_req_valid;
  logic       PrRd;
  logic       PrWr;
  logic [7:0] Index_proc;
  logic       hit;
  logic [1:0] Blk_accessed;
  logic [1:0] Current_MESI_state_proc;
  logic       Shared;
  logic       proc_rsp_valid;
  logic [1:0] Updated_MESI_state_proc;
  logic [1:0] LRU_replacement_proc;
  logic       snoop_req_valid;
  logic       BusRd;
  logic       BusRdX;
  logic       Invalidate;
  logic [1:0] Current_MESI_state_snoop;
  logic       snoop_rsp_valid;
  logic [1:0] Updated_MESI_state_snoop;
  logic       snoop_flush;

  coherence_lru_ctrl #(
    .ASSOCIATIVITY(ASSOC),
    .NUM_OF_SETS  (SETS),
    .MESI_SIZE    (2)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .init_done               (init_done),
    .proc_req_valid          (proc_req_valid),
    .PrRd                    (PrRd),
    .PrWr                    (PrWr),
    .Index_proc              (Index_proc),
    .hit                     (hit),
    .Blk_accessed            (Blk_accessed),
    .Current_MESI_state_proc (Current_MESI_state_proc),
    .Shared                  (Shared),
    .proc_rsp_valid          (proc_rsp_valid),
    .Updated_MESI_state_proc (Updated_MESI_state_proc),
    .LRU_replacement_proc    (LRU_replacement_proc),
    .snoop_req_valid         (snoop_req_valid),
    .BusRd                   (BusRd),
    .BusRdX                  (BusRdX),
    .Invalidate              (Invalidate),
    .Current_MESI_state_snoop(Current_MESI_state_snoop),
    .snoop_rsp_valid         (snoop_rsp_valid),
    .Updated_MESI_state_snoop(Updated_MESI_state_snoop),
    .snoop_flush             (snoop_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int last_victim;
  int last_pmesi;
  int last_smesi;
  int last_flush;

  // Reference PLRU state: node bit 0 means "victim is in the left subtree".
  bit mdl_tree [SETS][ASSOC-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_reset();
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < ASSOC - 1; n++)
        mdl_tree[s][n] = 1'b0;
  endfunction

  function automatic int mdl_victim(input int s);
    int node = 0;
    int way  = 0;
    for (int l = 0; l < WB; l++) begin
      int b = int'(mdl_tree[s][node]);
      way  = way * 2 + b;
      node = 2 * node + 1 + b;
    end
    return way;
  endfunction

  function automatic void mdl_touch(input int s, input int way);
    int node = 0;
    for (int l = 0; l < WB; l++) begin
      int dir = (way >> (WB - 1 - l)) & 1;
      mdl_tree[s][node] = (dir == 0);
      node = 2 * node + 1 + dir;
    end
  endfunction

  function automatic int mdl_proc(input bit h, input int cur, input bit rd, input bit wr, input bit sh);
    int c = h ? cur : ST_I;
    if (wr) return ST_M;
    if (rd && c == ST_I) begin
`ifdef MESI_EXCLUSIVE_EN
      return sh ? ST_S : ST_E;
`else
      return ST_S;
`endif
    end
    return c;
  endfunction

  function automatic int mdl_snoop(input int cur, input bit rd, input bit rdx, input bit inv);
    if (rdx || inv) return ST_I;
    if (rd) return (cur == ST_I) ? ST_I : ST_S;
    return cur;
  endfunction

  // One request cycle on either or both channels, checked one cycle later.
  task automatic cycle(input bit pv, input bit rd, input bit wr, input int idx,
                       input bit h, input int way, input int pcur, input bit sh,
                       input bit sv, input bit brd, input bit brdx, input bit binv,
                       input int scur, input string tag);
    int exp_v  = 0;
    int exp_pm = 0;
    int exp_sm = 0;
    int exp_fl = 0;
    if (pv) begin
      exp_v  = mdl_victim(idx);
      exp_pm = mdl_proc(h, pcur, rd, wr, sh);
      if (rd || wr) mdl_touch(idx, h ? way : exp_v);
    end
    if (sv) begin
      exp_sm = mdl_snoop(scur, brd, brdx, binv);
      exp_fl = (scur == ST_M && (brd || brdx || binv)) ? 1 : 0;
    end
    proc_req_valid           = pv;
    PrRd                     = rd;
    PrWr                     = wr;
    Index_proc               = 8'(idx);
    hit                      = h;
    Blk_accessed             = 2'(way);
    Current_MESI_state_proc  = 2'(pcur);
    Shared                   = sh;
    snoop_req_valid          = sv;
    BusRd                    = brd;
    BusRdX                   = brdx;
    Invalidate               = binv;
    Current_MESI_state_snoop = 2'(scur);
    tick();
    proc_req_valid  = 1'b0;
    snoop_req_valid = 1'b0;
    check({tag, "/proc_rsp_valid"}, 32'(proc_rsp_valid), 32'(pv));
    if (pv) begin
      check({tag, "/victim"}, 32'(LRU_replacement_proc), 32'(exp_v));
      check({tag, "/proc_mesi"}, 32'(Updated_MESI_state_proc), 32'(exp_pm));
    end
    check({tag, "/snoop_rsp_valid"}, 32'(snoop_rsp_valid), 32'(sv));
    if (sv) begin
      check({tag, "/snoop_mesi"}, 32'(Updated_MESI_state_snoop), 32'(exp_sm));
      check({tag, "/flush"}, 32'(snoop_flush), 32'(exp_fl));
    end
    last_victim = int'(LRU_replacement_proc);
    last_pmesi  = int'(Updated_MESI_state_proc);
    last_smesi  = int'(Updated_MESI_state_snoop);
    last_flush  = int'(snoop_flush);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/init_done"}, 32'(init_done), 0);
    check({tag, "/proc_rsp_valid"}, 32'(proc_rsp_valid), 0);
    check({tag, "/snoop_rsp_valid"}, 32'(snoop_rsp_valid), 0);
    check({tag, "/proc_mesi"}, 32'(Updated_MESI_state_proc), 0);
    check({tag, "/snoop_mesi"}, 32'(Updated_MESI_state_snoop), 0);
    check({tag, "/victim"}, 32'(LRU_replacement_proc), 0);
    check({tag, "/flush"}, 32'(snoop_flush), 0);
  endtask

  // Counts edges with rst low until init_done rises (bounded).
  task automatic wait_sweep(input string tag, input bit probe_drop);
    int n = 0;
    while (!init_done && n < 1000) begin
      if (probe_drop && n == 10) begin
        proc_req_valid = 1'b1;
        PrRd           = 1'b1;
        Index_proc     = 8'd5;
      end
      tick();
      n++;
      if (probe_drop && n == 11)
        check({tag, "/drop_before_init"}, 32'(proc_rsp_valid), 0);
      proc_req_valid = 1'b0;
      PrRd           = 1'b0;
    end
    check({tag, "/length"}, 32'(n), 32'(SETS));
  endtask

  initial begin
    int exp_seq [4] = '{0, 2, 1, 3};
    n_tests = 0;
    n_fail  = 0;
    rst                      = 1'b1;
    proc_req_valid           = 1'b0;
    PrRd                     = 1'b0;
    PrWr                     = 1'b0;
    Index_proc               = '0;
    hit                      = 1'b0;
    Blk_accessed             = '0;
    Current_MESI_state_proc  = '0;
    Shared                   = 1'b0;
    snoop_req_valid          = 1'b0;
    BusRd                    = 1'b0;
    BusRdX                   = 1'b0;
    Invalidate               = 1'b0;
    Current_MESI_state_snoop = '0;

    // Reset and sweep.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_sweep("sweep", 1'b1);
    mdl_reset();

    // PLRU order on set 5: four misses, then a hit on way 0 and a miss.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 5, 0, 0, ST_I, 1, 0, 0, 0, 0, ST_I, "plru_miss");
      check("plru_seq", 32'(last_victim), 32'(exp_seq[i]));
    end
    cycle(1, 1, 0, 5, 1, 0, ST_S, 1, 0, 0, 0, 0, ST_I, "plru_hit0");
    cycle(1, 1, 0, 5, 0, 0, ST_I, 1, 0, 0, 0, 0, ST_I, "plru_after_hit");
    check("plru_after_hit_const", 32'(last_victim), 2);

    // Back-to-back misses on set 9.
    cycle(1, 1, 0, 9, 0, 0, ST_I, 1, 0, 0, 0, 0, ST_I, "b2b_0");
    check("b2b_0_const", 32'(last_victim), 0);
    cycle(1, 0, 1, 9, 0, 0, ST_I, 1, 0, 0, 0, 0, ST_I, "b2b_1");
    check("b2b_1_const", 32'(last_victim), 2);

    // Processor MESI.
    cycle(1, 1, 0, 20, 0, 0, ST_M, 0, 0, 0, 0, 0, ST_I, "proc_rdmiss");
`ifdef MESI_EXCLUSIVE_EN
    check("proc_rdmiss_const", 32'(last_pmesi), ST_E);
`else
    check("proc_rdmiss_const", 32'(last_pmesi), ST_S);
`endif
    cycle(1, 0, 1, 20, 1, 1, ST_E, 0, 0, 0, 0, 0, ST_I, "proc_e_wr");
    check("proc_e_wr_const", 32'(last_pmesi), ST_M);
    cycle(1, 1, 1, 21, 1, 2, ST_S, 1, 0, 0, 0, 0, ST_I, "proc_s_rdwr");
    check("proc_s_rdwr_const", 32'(last_pmesi), ST_M);
    cycle(1, 0, 0, 21, 1, 3, ST_S, 0, 0, 0, 0, 0, ST_I, "proc_noop");
    check("proc_noop_const", 32'(last_pmesi), ST_S);
    cycle(1, 1, 0, 21, 0, 0, ST_I, 1, 0, 0, 0, 0, ST_I, "proc_after_noop");

    // Snoop MESI.
    cycle(0, 0, 0, 0, 0, 0, ST_I, 0, 1, 1, 0, 0, ST_M, "snp_m_rd");
    check("snp_m_rd_state", 32'(last_smesi), ST_S);
    check("snp_m_rd_flush", 32'(last_flush), 1);
    cycle(0, 0, 0, 0, 0, 0, ST_I, 0, 1, 1, 1, 0, ST_E, "snp_e_rdx");
    check("snp_e_rdx_state", 32'(last_smesi), ST_I);
    check("snp_e_rdx_flush", 32'(last_flush), 0);
    cycle(0, 0, 0, 0, 0, 0, ST_I, 0, 1, 0, 0, 1, ST_S, "snp_s_inv");
    check("snp_s_inv_state", 32'(last_smesi), ST_I);

    // Both channels on index 3 in the same cycle.
    cycle(1, 1, 0, 3, 0, 0, ST_I, 0, 1, 1, 0, 0, ST_E, "dual_idx3");

    // Randomized traffic over a few sets so trees get revisited.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), "rand");
    end

    // Reset in the middle of traffic overrides an accept at the same edge.
    cycle(1, 0, 1, 5, 1, 1, ST_M, 0, 1, 1, 0, 0, ST_M, "pre_rst");
    proc_req_valid  = 1'b1;
    PrRd            = 1'b1;
    Index_proc      = 8'd5;
    snoop_req_valid = 1'b1;
    BusRd           = 1'b1;
    rst             = 1'b1;
    tick();
    proc_req_valid  = 1'b0;
    snoop_req_valid = 1'b0;
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_sweep("resweep", 1'b0);
    mdl_reset();
    cycle(1, 1, 0, 5, 0, 0, ST_I, 1, 0, 0, 0, 0, ST_I, "post_rst");
    check("post_rst_const", 32'(last_victim), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coherence_lru_ctrl.md
# coherence_lru_ctrl

Clocked, parametrised successor to the per-cache MESI/pseudo-LRU controller. It sits between each processor's L1 cache block and the shared snoop bus. It holds a registered tree-PLRU state per set for any power-of-two associativity, and clears that state with a post-reset sweep. It returns registered MESI next-states for independent processor and snoop request channels, each with a valid handshake and a write-back (flush) indication.

## Interface
Parameters:
- ASSOCIATIVITY, 4, ways per set; power of two, 2..16; WAY_BITS = log2(ASSOCIATIVITY)
- NUM_OF_SETS, 256, sets; power of two; INDEX_SIZE = log2(NUM_OF_SETS)
- MESI_SIZE, 2, state width; encodings I=00, S=01, E=10, M=11

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- init_done  out  1  LRU sweep complete; requests accepted only when 1
- proc_req_valid  in  1  processor request strobe
- PrRd, PrWr  in  1 each  read / write; both set = write
- Index_proc  in  INDEX_SIZE  set of processor access
- hit  in  1  tag matched in set
- Blk_accessed  in  WAY_BITS  hitting way (ignored on miss)
- Current_MESI_state_proc  in  MESI_SIZE  state of hitting line
- Shared  in  1  another cache holds the line
- proc_rsp_valid  out  1  one-cycle response pulse
- Updated_MESI_state_proc  out  MESI_SIZE  next state
- LRU_replacement_proc  out  WAY_BITS  victim way before this access's update
- snoop_req_valid  in  1  snoop strobe
- BusRd, BusRdX, Invalidate  in  1 each  bus command
- Current_MESI_state_snoop  in  MESI_SIZE  snooped line state
- snoop_rsp_valid  out  1  one-cycle response pulse
- Updated_MESI_state_snoop  out  MESI_SIZE  next state
- snoop_flush  out  1  dirty data must be supplied or written back

## Operation
- LRU table: NUM_OF_SETS entries of ASSOCIATIVITY-1 bits. Node i has children 2i+1 and 2i+2. Bit 0 = victim lies in the left subtree.
- Victim: walk from the root following the bits of table[Index_proc].
- Update on an accepted request with PrRd|PrWr: target way = hit ? Blk_accessed : victim. Set every node on the path to point away from the target. Requests with neither PrRd nor PrWr leave the table unchanged but still respond.
- Sweep: rst clears the sweep counter and init_done. Once rst is low, one set is zeroed per cycle for NUM_OF_SETS cycles, then init_done=1. Requests with init_done=0 are dropped (no response).
- Proc MESI; a miss treats the current state as I:
  - I: PrRd&Shared → S; PrRd&!Shared → E; PrWr → M.
  - S: PrWr → M, else S.
  - E: PrWr → M, else E.
  - M → M.
- Snoop MESI. Priority BusRdX > Invalidate > BusRd; no command → state unchanged.
  - BusRdX: any state → I.
  - Invalidate: any state → I.
  - BusRd: M/E → S; S → S; I → I.
  - snoop_flush=1 iff current state is M and any command is present.
- The two channels are fully independent. Both may fire in the same cycle, including on the same index. Ordering is resolved upstream.

## Timing
- Request accepted at edge N (valid & init_done & !rst). Response outputs are registered and valid during cycle N+1. Valid is a one-cycle pulse; there is no backpressure.
- The LRU write happens at edge N. A same-set request accepted at edge N+1 sees the updated tree.
- Reset values: init_done=0, proc_rsp_valid=0, snoop_rsp_valid=0, Updated_MESI_state_proc=00, Updated_MESI_state_snoop=00, LRU_replacement_proc=0, snoop_flush=0.
- rst asserted mid-operation overrides any accept at that edge. Pending responses are cleared and the sweep restarts.
- Sweep length is exactly NUM_OF_SETS cycles after the first edge with rst=0.

## Configuration
- MESI_EXCLUSIVE_EN
  - Defined: full MESI; I+PrRd+!Shared → E.
  - Undefined: MSI mode; I+PrRd → S regardless of Shared, and E is never produced. E inputs on either channel are still decoded as above.

## Test plan
- Sweep: rst high 3 cycles, NUM_OF_SETS=256 → init_done rises after exactly 256 cycles. A proc request issued at cycle 10 gets no proc_rsp_valid.
- PLRU order, ASSOCIATIVITY=4, set 5, four consecutive misses → LRU_replacement_proc = 0,2,1,3. Then a hit on way 0 followed by a miss → victim 2.
- Back-to-back: misses on set 9 at cycles N and N+1 → victims 0 then 2, with responses at N+1 and N+2.
- Proc MESI: miss PrRd Shared=0 → E (macro defined) or S (undefined). Hit E + PrWr → M. Hit S + PrRd+PrWr → M.
- Snoop: M+BusRd → S, flush=1. E+BusRd+BusRdX → I, flush=0. S+Invalidate → I. Same-cycle proc and snoop on index 3 → both rsp_valid together.
- Reset mid-op: proc request with rst=1 at the same edge → no response at the next cycle, init_done=0, outputs at reset values.
